// File: rtl/act_pkg.sv
// Shared definitions for the streaming activation stage.
//   LANE_W      element width: sign-magnitude, MSB = sign, 17 fraction bits
//   act_mode_e  per-frame activation selector
//   is_zero     true for +0 and -0 (magnitude field is zero)
package act_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_LEAKY  = 2'b10,
    ACT_CLIP   = 2'b11
  } act_mode_e;

  function automatic logic is_zero(input logic [LANE_W-1:0] x);
    return (x[LANE_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational activation of one sign-magnitude element.
//   x      in   LANE_W   input element
//   mode   in   2        activation mode
//   shift  in   SHW      leaky right shift applied to the magnitude
//   clip   in   LANE_W   clipped-ReLU ceiling (positive)
//   y      out  LANE_W   activated element
//   zero   out  1        y has zero magnitude
module act_lane
  import act_pkg::*;
#(
  parameter int SHW = 5
) (
  input  logic [LANE_W-1:0] x,
  input  act_mode_e         mode,
  input  logic [SHW-1:0]    shift,
  input  logic [LANE_W-1:0] clip,
  output logic [LANE_W-1:0] y,
  output logic              zero
);

  logic              sgn;
  logic [LANE_W-2:0] mag;
  logic [LANE_W-2:0] shifted;

  always_comb begin
    sgn     = x[LANE_W-1];
    mag     = x[LANE_W-2:0];
    shifted = mag >> shift;
    y       = x;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = sgn ? '0 : x;
      // A negative that shifts down to zero magnitude becomes +0, never -0.
      ACT_LEAKY: begin
        if (sgn) y = (shifted == '0) ? '0 : {1'b1, shifted};
      end
      ACT_CLIP: begin
        if (sgn)                          y = '0;
        else if (mag > clip[LANE_W-2:0])  y = clip;
      end
      default:    y = x;
    endcase
    zero = is_zero(y);
  end

endmodule

// File: rtl/act_stream_unit.sv
// Streaming two-stage activation unit: LANES elements per beat, BEATS beats per
// frame. Settings are latched on the first beat of each frame.
//   clk, rst_n     clock, asynchronous active-low reset
//   mode_i         activation mode, sampled on the beat-0 accept
//   shift_i        leaky shift, sampled on the beat-0 accept
//   clip_i         clip ceiling, sampled on the beat-0 accept
//   in_valid/in_ready/in_data       input beat
//   out_valid/out_ready/out_data    output beat
//   out_last       final beat of a frame
//   out_zero_cnt   zero outputs in the frame, meaningful only with out_last
//
// Handshake: a beat transfers on a rising edge where valid && ready. A source
// holding valid keeps its data stable until the transfer. in_ready depends
// combinationally on out_ready (stage-by-stage ready chain, no skid buffer).
module act_stream_unit
  import act_pkg::*;
#(
  parameter int LANES = 6,
  parameter int BEATS = 6,
  parameter int SHW   = 5,
  localparam int ZCW  = $clog2(LANES*BEATS+1),
  localparam int CW   = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode_i,
  input  logic [SHW-1:0]          shift_i,
  input  logic [LANE_W-1:0]       clip_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_last,
  output logic [ZCW-1:0]          out_zero_cnt
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS-1);

  // Frame settings, valid for the beat currently in stage 1.
  logic [CW-1:0]           beat_cnt;
  act_mode_e               mode_q;
  logic [SHW-1:0]          shift_q;
  logic [LANE_W-1:0]       clip_q;

  // Stage 1: registered input beat.
  logic                    v1;
  logic                    last1;
  logic [LANES*LANE_W-1:0] d1;

  // Stage 2 valid plus frame zero accumulator.
  logic                    v2;
  logic [ZCW-1:0]          acc;

  logic                    rdy1, rdy2, accept, load2;
  logic [LANES*LANE_W-1:0] y_all;
  logic [LANES-1:0]        zero_v;
  logic [ZCW-1:0]          beat_zeros;

  assign rdy2      = !v2 || out_ready;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = rdy1;
  assign accept    = in_valid && in_ready;
  assign load2     = v1 && rdy2;
  assign out_valid = v2;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(.SHW(SHW)) u_lane (
      .x     (d1[g*LANE_W +: LANE_W]),
      .mode  (mode_q),
      .shift (shift_q),
      .clip  (clip_q),
      .y     (y_all[g*LANE_W +: LANE_W]),
      .zero  (zero_v[g])
    );
  end

  always_comb begin
    beat_zeros = '0;
    for (int i = 0; i < LANES; i++) beat_zeros = beat_zeros + ZCW'(zero_v[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      mode_q       <= ACT_BYPASS;
      shift_q      <= '0;
      clip_q       <= '0;
      v1           <= 1'b0;
      last1        <= 1'b0;
      d1           <= '0;
      v2           <= 1'b0;
      acc          <= '0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_zero_cnt <= '0;
    end else begin
      // Settings only change when a new beat 0 enters stage 1, so the lane
      // logic always sees the settings belonging to the beat it computes.
      if (accept) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        d1       <= in_data;
        last1    <= (beat_cnt == LAST_BEAT);
        if (beat_cnt == '0) begin
          mode_q  <= act_mode_e'(mode_i);
          shift_q <= shift_i;
          clip_q  <= clip_i;
        end
      end
      if (rdy1) v1 <= in_valid;

      if (rdy2) begin
        v2       <= v1;
        out_last <= v1 && last1;
      end
      if (load2) begin
        out_data <= y_all;
        if (last1) begin
          out_zero_cnt <= acc + beat_zeros;
          acc          <= '0;
        end else begin
          out_zero_cnt <= '0;
          acc          <= acc + beat_zeros;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_stream_unit.sv
module tb_act_stream_unit;

  localparam int LANES = 6;
  localparam int BEATS = 6;
  localparam int SHW   = 5;
  localparam int W     = 32;
  localparam int DW    = LANES*W;
  localparam int ZCW   = $clog2(LANES*BEATS+1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     mode_i;
  logic [SHW-1:0] shift_i;
  logic [W-1:0]   clip_i;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_last;
  logic [ZCW-1:0] out_zero_cnt;

  act_stream_unit #(.LANES(LANES), .BEATS(BEATS), .SHW(SHW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode_i),
    .shift_i      (shift_i),
    .clip_i       (clip_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_zero_cnt (out_zero_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0]  exp_q[$];
  logic           exp_last_q[$];
  logic [ZCW-1:0] exp_zc_q[$];

  // reference frame state
  int             m_cnt;
  int             m_acc;
  logic [1:0]     m_mode;
  logic [SHW-1:0] m_shift;
  logic [W-1:0]   m_clip;

  // bench controls
  bit             stall_en;
  bit             accepted;
  bit             hold_pending;
  logic [DW-1:0]  hold_data;
  logic           hold_last;
  logic [DW-1:0]  last_out_data;
  logic [ZCW-1:0] last_out_zc;
  logic [1:0]     cfg_mode;
  logic [SHW-1:0] cfg_shift;
  logic [W-1:0]   cfg_clip;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference activation of one element.
  function automatic logic [W-1:0] ref_act(input logic [W-1:0] x, input logic [1:0] mode,
                                           input logic [SHW-1:0] sh, input logic [W-1:0] clip);
    logic         s;
    logic [W-2:0] m;
    s = x[W-1];
    m = x[W-2:0];
    if (mode == 2'b00) return x;
    if (m == '0) return '0;
    case (mode)
      2'b01: return s ? '0 : x;
      2'b10: begin
        if (!s) return x;
        m = m >> sh;
        return (m == '0) ? '0 : {1'b1, m};
      end
      default: begin
        if (s) return '0;
        return (m > clip[W-2:0]) ? clip : x;
      end
    endcase
  endfunction

  task automatic model_push(input logic [DW-1:0] data, input logic [1:0] mode,
                            input logic [SHW-1:0] sh, input logic [W-1:0] clip);
    logic [DW-1:0] y;
    logic [W-1:0]  e;
    int            z;
    bit            last;
    if (m_cnt == 0) begin
      m_mode  = mode;
      m_shift = sh;
      m_clip  = clip;
    end
    z = 0;
    for (int l = 0; l < LANES; l++) begin
      e = ref_act(data[l*W +: W], m_mode, m_shift, m_clip);
      y[l*W +: W] = e;
      if (e[W-2:0] == '0) z++;
    end
    last  = (m_cnt == BEATS-1);
    m_acc = m_acc + z;
    exp_q.push_back(y);
    exp_last_q.push_back(last);
    exp_zc_q.push_back(last ? ZCW'(m_acc) : '0);
    if (last) begin
      m_acc = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: apply inputs on the falling edge, then observe what will
  // transfer on the next rising edge.
  task automatic cycle(input logic v, input logic [DW-1:0] data);
    logic [DW-1:0]  ed;
    logic           el;
    logic [ZCW-1:0] ez;
    @(negedge clk);
    in_valid  = v;
    in_data   = data;
    mode_i    = cfg_mode;
    shift_i   = cfg_shift;
    clip_i    = cfg_clip;
    out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    if (hold_pending) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, hold_data);
      check("stall_last", out_last, hold_last);
      hold_pending = 0;
    end
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          ed = exp_q.pop_front();
          el = exp_last_q.pop_front();
          ez = exp_zc_q.pop_front();
          check("out_data", out_data, ed);
          check("out_last", out_last, el);
          if (el) check("out_zero_cnt", out_zero_cnt, ez);
        end
        last_out_data = out_data;
        if (out_last) last_out_zc = out_zero_cnt;
      end else begin
        hold_pending = 1;
        hold_data    = out_data;
        hold_last    = out_last;
      end
    end
    accepted = v && in_ready;
    if (accepted) model_push(data, cfg_mode, cfg_shift, cfg_clip);
  endtask

  task automatic send_beat(input logic [DW-1:0] data);
    int guard;
    if (stall_en && $urandom_range(0, 3) == 0) cycle(1'b0, '0);
    guard = 0;
    do begin
      cycle(1'b1, data);
      guard++;
    end while (!accepted && guard < 100);
    if (!accepted) check("accept_timeout", accepted, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0);
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] b;
    logic [W-1:0]  e;
    for (int l = 0; l < LANES; l++) begin
      e = $urandom;
      if ($urandom_range(0, 7) == 0) e[W-2:0] = '0;
      b[l*W +: W] = e;
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] fill_beat(input logic [W-1:0] v);
    logic [DW-1:0] b;
    for (int l = 0; l < LANES; l++) b[l*W +: W] = v;
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_zero_cnt", out_zero_cnt, '0);
    check("rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    exp_last_q.delete();
    exp_zc_q.delete();
    m_cnt = 0;
    m_acc = 0;
    hold_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] b;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_mode  = 2'b00;
    cfg_shift = '0;
    cfg_clip  = '0;
    mode_i    = 2'b00;
    shift_i   = '0;
    clip_i    = '0;
    stall_en  = 0;
    m_cnt     = 0;
    m_acc     = 0;
    #2;
    do_reset();

    // 1: ReLU, latency 2, negative lane zeroed
    cfg_mode = 2'b01;
    b = fill_beat(32'h0006487e);
    b[4*W +: W] = 32'hF006487e;
    send_beat(b);
    cycle(1'b0, '0);
    check("lat_cycle1", out_valid, 1'b0);
    cycle(1'b0, '0);
    check("lat_cycle2", out_valid, 1'b1);
    check("t1_lane4", last_out_data[4*W +: W], 32'h0);
    check("t1_lane0", last_out_data[0 +: W], 32'h0006487e);
    for (int i = 1; i < BEATS; i++) send_beat(rand_beat());
    idle(3);

    // 2: leaky, shift 3
    cfg_mode  = 2'b10;
    cfg_shift = 5'd3;
    b = rand_beat();
    b[0 +: W] = 32'hF006487e;
    b[W +: W] = 32'h80000005;
    send_beat(b);
    idle(2);
    check("t2_leaky", last_out_data[0 +: W], 32'h8E00C90F);
    check("t2_leaky_z", last_out_data[W +: W], 32'h0);
    for (int i = 1; i < BEATS; i++) send_beat(rand_beat());
    idle(3);

    // 3: clipped ReLU
    cfg_mode = 2'b11;
    cfg_clip = 32'h00020000;
    b = rand_beat();
    b[0 +: W] = 32'h0006487e;
    b[W +: W] = 32'h00010000;
    send_beat(b);
    idle(2);
    check("t3_clip", last_out_data[0 +: W], 32'h00020000);
    check("t3_pass", last_out_data[W +: W], 32'h00010000);
    for (int i = 1; i < BEATS; i++) send_beat(rand_beat());
    idle(3);

    // 4: two negatives per frame; mode change mid-frame deferred
    for (int f = 0; f < 2; f++) begin
      cfg_mode = 2'b01;
      for (int i = 0; i < BEATS; i++) begin
        if (i == 3) cfg_mode = 2'b00;
        for (int l = 0; l < LANES; l++) b[l*W +: W] = {1'b0, 31'($urandom) | 31'd1};
        if (i == 1) b[2*W +: W] = 32'h80001234;
        if (i == 4) b[5*W +: W] = 32'hC0000001;
        send_beat(b);
      end
      idle(3);
      if (f == 0) check("t4_zero_cnt", last_out_zc, 2);
    end

    // 5: random back-pressure, back-to-back frames
    stall_en = 1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < BEATS; i++) begin
        if (i == 0 || $urandom_range(0, 3) == 0) begin
          cfg_mode  = 2'($urandom_range(0, 3));
          cfg_shift = SHW'($urandom_range(0, 31));
          cfg_clip  = {1'b0, 31'($urandom)};
        end
        send_beat(rand_beat());
      end
    end
    stall_en = 0;
    idle(6);

    // 6: reset during a frame, next frame starts clean
    cfg_mode = 2'b01;
    for (int i = 0; i < 3; i++) send_beat(rand_beat());
    do_reset();
    for (int i = 0; i < BEATS; i++) send_beat(rand_beat());

    // drain
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle(1'b0, '0);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
